// File: rtl/node_phase_ctrl.sv
// Per-node EER-RL round sequencer: setup/cluster/schedule phases, packet gating into node-info,
// TDMA slot/frame counting and own-slot transmit requests. Optional DROP_CNT_EN adds drop_count.
module node_phase_ctrl #(
  parameter int FRAME_SLOTS  = 16,
  parameter int ROUND_FRAMES = 8,
  parameter int TIMEOUT      = 1024,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        start,
  input  logic        pkt_valid,
  input  logic [2:0]  pkt_type,
  input  logic        role,
  input  logic        low_E,
  input  logic [15:0] my_timeslot,
  input  logic        slot_tick,
  input  logic        tx_ack,
  output logic        en_MNI,
  output logic [2:0]  fPktType,
  output logic [2:0]  phase,
  output logic        tx_req,
  output logic [2:0]  tx_pkt_type,
  output logic        round_done,
  output logic        timeout
`ifdef DROP_CNT_EN
  ,
  output logic [7:0]  drop_count
`endif
);

  localparam int SLOT_W  = (FRAME_SLOTS > 1) ? $clog2(FRAME_SLOTS) : 1;
  localparam int FRAME_W = (ROUND_FRAMES > 1) ? $clog2(ROUND_FRAMES) : 1;
  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(FRAME_SLOTS - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(ROUND_FRAMES - 1);
  localparam logic [CNT_W-1:0]   WD_LAST    = CNT_W'(TIMEOUT - 1);

  localparam logic [2:0] T_HB    = 3'b000;
  localparam logic [2:0] T_CH    = 3'b001;
  localparam logic [2:0] T_SCHED = 3'b100;
  localparam logic [2:0] T_DATA  = 3'b101;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    CLUSTER = 3'd2,
    SCHED   = 3'd3,
    STEADY  = 3'd4
  } phase_t;

  phase_t             state, state_d;
  logic [CNT_W-1:0]   wd_cnt, wd_d;
  logic [SLOT_W-1:0]  slot_cnt, slot_d;
  logic [FRAME_W-1:0] frame_cnt, frame_d;
  logic               ch_pend, ch_pend_d;
  logic               en_d, done_d, to_d, tx_req_d;
  logic [2:0]         type_d, tx_type_d;
  logic               accept;

  assign phase = state;

  // A packet is accepted only when its type is the one the current phase waits for;
  // a low-energy abort in STEADY swallows the data packet of that cycle.
  always_comb begin
    accept = 1'b0;
    if (pkt_valid) begin
      case (state)
        SETUP:   accept = (pkt_type == T_HB);
        CLUSTER: accept = (pkt_type == T_CH);
        SCHED:   accept = (pkt_type == T_SCHED);
        STEADY:  accept = (pkt_type == T_DATA) && !low_E;
        default: accept = 1'b0;
      endcase
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_d   = state;
    wd_d      = wd_cnt;
    slot_d    = slot_cnt;
    frame_d   = frame_cnt;
    ch_pend_d = 1'b0;
    en_d      = 1'b0;
    type_d    = fPktType;
    done_d    = 1'b0;
    to_d      = 1'b0;
    tx_req_d  = tx_req;
    tx_type_d = tx_pkt_type;

    if (tx_req && tx_ack) tx_req_d = 1'b0;

    // Cluster head issues the schedule the cycle after its CH announce was accepted.
    if (ch_pend && role && !tx_req) begin
      tx_req_d  = 1'b1;
      tx_type_d = T_SCHED;
    end

    case (state)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          wd_d    = '0;
        end
      end
      SETUP, CLUSTER, SCHED: begin
        if (accept) begin
          wd_d = '0;
          case (state)
            SETUP:   state_d = CLUSTER;
            CLUSTER: begin
              state_d   = SCHED;
              ch_pend_d = 1'b1;
            end
            default: begin
              state_d = STEADY;
              slot_d  = '0;
              frame_d = '0;
            end
          endcase
        end else if (wd_cnt == WD_LAST) begin
          state_d = IDLE;
          to_d    = 1'b1;
          wd_d    = '0;
        end else begin
          wd_d = wd_cnt + 1'b1;
        end
      end
      STEADY: begin
        if (low_E) begin
          state_d = SETUP;
          done_d  = 1'b1;
          slot_d  = '0;
          frame_d = '0;
          wd_d    = '0;
        end else if (slot_tick) begin
          if ((16'(slot_cnt) == my_timeslot) && !tx_req) begin
            tx_req_d  = 1'b1;
            tx_type_d = T_DATA;
          end
          if (slot_cnt == SLOT_LAST) begin
            slot_d = '0;
            if (frame_cnt == FRAME_LAST) begin
              frame_d = '0;
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              frame_d = frame_cnt + 1'b1;
            end
          end else begin
            slot_d = slot_cnt + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      en_d   = 1'b1;
      type_d = pkt_type;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      wd_cnt      <= '0;
      slot_cnt    <= '0;
      frame_cnt   <= '0;
      ch_pend     <= 1'b0;
      en_MNI      <= 1'b0;
      fPktType    <= 3'b000;
      round_done  <= 1'b0;
      timeout     <= 1'b0;
      tx_req      <= 1'b0;
      tx_pkt_type <= 3'b000;
    end else begin
      state       <= state_d;
      wd_cnt      <= wd_d;
      slot_cnt    <= slot_d;
      frame_cnt   <= frame_d;
      ch_pend     <= ch_pend_d;
      en_MNI      <= en_d;
      fPktType    <= type_d;
      round_done  <= done_d;
      timeout     <= to_d;
      tx_req      <= tx_req_d;
      tx_pkt_type <= tx_type_d;
    end
  end

`ifdef DROP_CNT_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      drop_count <= 8'd0;
    end else if (pkt_valid && !accept && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_node_phase_ctrl.sv
// Self-checking bench for node_phase_ctrl (FRAME_SLOTS=4, ROUND_FRAMES=2, TIMEOUT=16);
// en_MNI and tx_req launches are scored against queues filled as stimulus is driven.
module tb_node_phase_ctrl;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        start = 1'b0;
  logic        pkt_valid = 1'b0;
  logic [2:0]  pkt_type = 3'b000;
  logic        role = 1'b0;
  logic        low_E = 1'b0;
  logic [15:0] my_timeslot = 16'd2;
  logic        slot_tick = 1'b0;
  logic        tx_ack = 1'b0;
  logic        en_MNI;
  logic [2:0]  fPktType;
  logic [2:0]  phase;
  logic        tx_req;
  logic [2:0]  tx_pkt_type;
  logic        round_done;
  logic        timeout;
`ifdef DROP_CNT_EN
  logic [7:0]  drop_count;
`endif

  int checks = 0;
  int failures = 0;
  logic [2:0] en_q[$];
  logic [2:0] tx_q[$];
  logic       prev_tx = 1'b0;

  node_phase_ctrl #(
    .FRAME_SLOTS(4),
    .ROUND_FRAMES(2),
    .TIMEOUT(16),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .start(start),
    .pkt_valid(pkt_valid),
    .pkt_type(pkt_type),
    .role(role),
    .low_E(low_E),
    .my_timeslot(my_timeslot),
    .slot_tick(slot_tick),
    .tx_ack(tx_ack),
    .en_MNI(en_MNI),
    .fPktType(fPktType),
    .phase(phase),
    .tx_req(tx_req),
    .tx_pkt_type(tx_pkt_type),
    .round_done(round_done),
    .timeout(timeout)
`ifdef DROP_CNT_EN
    ,
    .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  // One clock, then score any en_MNI strobe and any new tx request against the queues.
  task automatic step();
    logic [2:0] exp;
    @(posedge clk);
    #1;
    if (en_MNI === 1'b1) begin
      checks++;
      if (en_q.size() == 0) begin
        failures++;
        $display("FAIL en_MNI_unexpected got fPktType=%b, no accept expected", fPktType);
      end else begin
        exp = en_q.pop_front();
        if (fPktType !== exp) begin
          failures++;
          $display("FAIL en_MNI_type got %b expected %b", fPktType, exp);
        end
      end
    end
    if (tx_req === 1'b1 && prev_tx === 1'b0) begin
      checks++;
      if (tx_q.size() == 0) begin
        failures++;
        $display("FAIL tx_req_unexpected got tx_pkt_type=%b, no request expected", tx_pkt_type);
      end else begin
        exp = tx_q.pop_front();
        if (tx_pkt_type !== exp) begin
          failures++;
          $display("FAIL tx_pkt_type got %b expected %b", tx_pkt_type, exp);
        end
      end
    end
    prev_tx = tx_req;
  endtask

  task automatic send(input logic [2:0] t, input bit accepted);
    pkt_valid = 1'b1;
    pkt_type  = t;
    if (accepted) en_q.push_back(t);
    step();
    pkt_valid = 1'b0;
  endtask

  task automatic apply_reset();
    nrst = 1'b0; start = 1'b0; pkt_valid = 1'b0; slot_tick = 1'b0;
    tx_ack = 1'b0; low_E = 1'b0; role = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    en_q.delete();
    tx_q.delete();
    prev_tx = 1'b0;
    nrst = 1'b1;
  endtask

  task automatic drained(input string name);
    checks++;
    if (en_q.size() != 0 || tx_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain got en_pending=%0d tx_pending=%0d expected 0 0", name, en_q.size(), tx_q.size());
    end
  endtask

  // start, HB, CH (role low), schedule: walks IDLE through STEADY.
  task automatic go_steady();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (phase !== 3'd1) begin failures++; $display("FAIL enter_setup got phase=%0d expected 1", phase); end
    send(3'b000, 1'b1);
    checks++;
    if (phase !== 3'd2) begin failures++; $display("FAIL enter_cluster got phase=%0d expected 2", phase); end
    send(3'b001, 1'b1);
    checks++;
    if (phase !== 3'd3) begin failures++; $display("FAIL enter_sched got phase=%0d expected 3", phase); end
    step();
    checks++;
    if (tx_req !== 1'b0) begin failures++; $display("FAIL member_no_sched_tx got tx_req=%b expected 0", tx_req); end
    send(3'b100, 1'b1);
    checks++;
    if (phase !== 3'd4) begin failures++; $display("FAIL enter_steady got phase=%0d expected 4", phase); end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({en_MNI, fPktType, phase, tx_req, tx_pkt_type, round_done, timeout} !== 13'b0) begin
      failures++;
      $display("FAIL reset_outputs got %b expected all zero",
               {en_MNI, fPktType, phase, tx_req, tx_pkt_type, round_done, timeout});
    end
    apply_reset();
    step();
    checks++;
    if (phase !== 3'd0) begin failures++; $display("FAIL reset_idle got phase=%0d expected 0", phase); end
  endtask

  task automatic test_nominal_round();
    int s;
    int f;
    bit exp_done;
    apply_reset();
    my_timeslot = 16'd2;
    go_steady();
    s = 0;
    f = 0;
    for (int t = 0; t < 8; t++) begin
      slot_tick = 1'b1;
      exp_done = (s == 3) && (f == 1);
      if (s == 2) tx_q.push_back(3'b101);
      step();
      slot_tick = 1'b0;
      checks++;
      if (round_done !== exp_done) begin
        failures++;
        $display("FAIL round_done_tick%0d got %b expected %b", t, round_done, exp_done);
      end
      checks++;
      if (phase !== (exp_done ? 3'd0 : 3'd4)) begin
        failures++;
        $display("FAIL phase_tick%0d got %0d expected %0d", t, phase, exp_done ? 0 : 4);
      end
      if (s == 3) begin s = 0; f++; end else s++;
      if (tx_req) begin
        tx_ack = 1'b1;
        step();
        tx_ack = 1'b0;
        checks++;
        if (tx_req !== 1'b0) begin failures++; $display("FAIL tx_drop_after_ack got %b expected 0", tx_req); end
      end
      if (t == 1) send(3'b101, 1'b1);
      else step();
      if (exp_done) begin
        checks++;
        if (round_done !== 1'b0) begin failures++; $display("FAIL round_done_width got %b expected 0", round_done); end
      end
    end
    drained("nominal");
  endtask

  task automatic test_ch_role();
    apply_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    send(3'b000, 1'b1);
    role = 1'b1;
    send(3'b001, 1'b1);
    tx_q.push_back(3'b100);
    step();
    checks++;
    if (tx_req !== 1'b1) begin failures++; $display("FAIL ch_tx_raise got tx_req=%b expected 1", tx_req); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (tx_req !== 1'b1 || tx_pkt_type !== 3'b100) begin
        failures++;
        $display("FAIL ch_tx_hold%0d got req=%b type=%b expected 1 100", i, tx_req, tx_pkt_type);
      end
    end
    tx_ack = 1'b1;
    step();
    tx_ack = 1'b0;
    checks++;
    if (tx_req !== 1'b0) begin failures++; $display("FAIL ch_tx_drop got %b expected 0", tx_req); end
    tx_ack = 1'b1;
    step();
    tx_ack = 1'b0;
    checks++;
    if (tx_req !== 1'b0) begin failures++; $display("FAIL stray_ack got tx_req=%b expected 0", tx_req); end
    role = 1'b0;
    drained("ch_role");
  endtask

  task automatic test_watchdog();
    apply_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      step();
      checks++;
      if (phase !== 3'd1 || timeout !== 1'b0) begin
        failures++;
        $display("FAIL wd_wait%0d got phase=%0d timeout=%b expected 1 0", i, phase, timeout);
      end
    end
    step();
    checks++;
    if (timeout !== 1'b1 || phase !== 3'd0) begin
      failures++;
      $display("FAIL wd_expire got timeout=%b phase=%0d expected 1 0", timeout, phase);
    end
    step();
    checks++;
    if (timeout !== 1'b0) begin failures++; $display("FAIL wd_pulse_width got %b expected 0", timeout); end
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (15) step();
    send(3'b000, 1'b1);
    checks++;
    if (timeout !== 1'b0 || phase !== 3'd2) begin
      failures++;
      $display("FAIL wd_accept_wins got timeout=%b phase=%0d expected 0 2", timeout, phase);
    end
    drained("watchdog");
  endtask

  task automatic test_wrong_type();
    logic [2:0] bad [3];
    bad[0] = 3'b001; bad[1] = 3'b101; bad[2] = 3'b111;
    apply_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(bad[i], 1'b0);
      checks++;
      if (en_MNI !== 1'b0 || phase !== 3'd1) begin
        failures++;
        $display("FAIL filter_%b got en_MNI=%b phase=%0d expected 0 1", bad[i], en_MNI, phase);
      end
    end
`ifdef DROP_CNT_EN
    checks++;
    if (drop_count !== 8'd3) begin failures++; $display("FAIL drop_count got %0d expected 3", drop_count); end
`endif
    drained("wrong_type");
  endtask

  task automatic test_low_e();
    apply_reset();
    my_timeslot = 16'd2;
    go_steady();
    for (int i = 0; i < 2; i++) begin
      slot_tick = 1'b1;
      step();
      slot_tick = 1'b0;
      step();
    end
    slot_tick = 1'b1;
    low_E = 1'b1;
    send(3'b101, 1'b0);
    slot_tick = 1'b0;
    low_E = 1'b0;
    checks++;
    if (phase !== 3'd1 || round_done !== 1'b1 || tx_req !== 1'b0 || en_MNI !== 1'b0) begin
      failures++;
      $display("FAIL low_e_abort got phase=%0d done=%b req=%b en=%b expected 1 1 0 0",
               phase, round_done, tx_req, en_MNI);
    end
    checks++;
    if (dut.slot_cnt !== '0 || dut.frame_cnt !== '0) begin
      failures++;
      $display("FAIL low_e_counters got slot=%0d frame=%0d expected 0 0", dut.slot_cnt, dut.frame_cnt);
    end
    step();
    checks++;
    if (round_done !== 1'b0 || phase !== 3'd1 || tx_req !== 1'b0) begin
      failures++;
      $display("FAIL low_e_after got done=%b phase=%0d req=%b expected 0 1 0", round_done, phase, tx_req);
    end
    drained("low_e");
  endtask

  task automatic test_async_reset();
    apply_reset();
    my_timeslot = 16'd2;
    go_steady();
    for (int i = 0; i < 3; i++) begin
      slot_tick = 1'b1;
      if (i == 2) tx_q.push_back(3'b101);
      step();
      slot_tick = 1'b0;
      if (i < 2) step();
    end
    checks++;
    if (tx_req !== 1'b1) begin failures++; $display("FAIL pre_reset_tx got %b expected 1", tx_req); end
    #2;
    nrst = 1'b0;
    #1;
    checks++;
    if ({en_MNI, fPktType, phase, tx_req, tx_pkt_type, round_done, timeout} !== 13'b0) begin
      failures++;
      $display("FAIL async_reset got %b expected all zero",
               {en_MNI, fPktType, phase, tx_req, tx_pkt_type, round_done, timeout});
    end
    @(posedge clk);
    #1;
    checks++;
    if (round_done !== 1'b0 || phase !== 3'd0) begin
      failures++;
      $display("FAIL async_reset_hold got done=%b phase=%0d expected 0 0", round_done, phase);
    end
    en_q.delete();
    tx_q.delete();
    prev_tx = 1'b0;
    nrst = 1'b1;
    drained("async_reset");
  endtask

  initial begin
    test_reset();
    test_nominal_round();
    test_ch_role();
    test_watchdog();
    test_wrong_type();
    test_low_e();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
